uart_tx: RTL and testbench
==========================

# uart_tx

UART transmit stage that serialises bytes onto the TX line with the same frame format and 16-clock bit period as the UART receiver. Frame: start bit, 8 data bits LSB first, parity bit, stop bit. A one-entry holding buffer in front of the shift register accepts the next byte while the current frame is still on the wire, so frames can go out back-to-back. It sits between the core-side byte source and the serial pin.

## Interface
- PARITY_ODD, default 0: 0 = even parity (parity bit = XOR of data); 1 = odd parity (parity bit = XNOR of data).
- Clk  input  1  core clock; the bit period is 16 Clk cycles.
- Rst  input  1  asynchronous, active-high reset.
- Clear  input  1  synchronous clear; same effect as reset, applied on the clock edge.
- InData  input  8  byte to transmit; sampled on an accepted transfer.
- InValid  input  1  InData is valid.
- InReady  output  1  holding buffer is empty; a transfer occurs on a Clk edge where InValid && InReady.
- TX  output  1  serial line, idle high; driven from a register.
- Busy  output  1  high while a frame is in progress (state != IDLE) or the holding buffer is full.
- FrameDone  output  1  one-cycle pulse in the cycle after a stop bit completes.

## Operation
- Reset and Clear values: TX=1, InReady=1, Busy=0, FrameDone=0, state=IDLE, bit_cnt=0, data_cnt=0, holding buffer empty, shift register 0.
- Holding buffer: hold_valid, hold_data[7:0]. InReady = ~hold_valid, decoded from the register with no combinational path from InValid. An accepted transfer sets hold_valid and captures InData. Loading the buffer into the shift register clears hold_valid. Accept and load never occur on the same edge, because InReady=0 whenever a load is possible.
- bit_cnt[3:0] increments every cycle outside IDLE and wraps 15 -> 0. bit_end = (bit_cnt == 15).
- States:
  - IDLE: TX=1. If hold_valid, load the shift register, compute the parity bit from hold_data, clear hold_valid, go to START, set TX<=0, bit_cnt<=0.
  - START: TX=0 for 16 cycles. On bit_end, go to DATA and set TX<=shift[0].
  - DATA: 8 bits LSB first, each for 16 cycles. On bit_end, shift right and increment data_cnt[2:0]. On bit_end with data_cnt==7, go to PARITY, set TX<=parity, data_cnt<=0.
  - PARITY: 16 cycles. On bit_end, go to STOP with TX<=1.
  - STOP: TX=1 for 16 cycles. On bit_end, FrameDone<=1.
    - If hold_valid: load the buffer and go directly to START with TX<=0. There is no idle gap.
    - Otherwise go to IDLE.
- Parity is computed on the data byte only. Example: 0xA5 has four ones, so the even parity bit is 0 and the odd parity bit is 1.
- InValid held with InReady=0: no transfer occurs; the source must hold InData.
- Clear or Rst mid-frame aborts the frame. TX returns high immediately (asynchronously for Rst, on the next edge for Clear). A buffered byte is discarded and FrameDone does not pulse.
- Clear and an accept condition on the same edge: Clear wins and the byte is dropped.
- Unused state encodings recover to IDLE with TX=1.

## Timing
- Accept at edge N from IDLE with an empty buffer: hold_valid=1 after edge N. At edge N+1, TX falls (start bit) and InReady returns to 1.
- Bit k of the frame (0 = start, 1..8 = data, 9 = parity, 10 = stop) is on TX from edge N+1+16k to edge N+1+16(k+1).
- Frame length: 176 cycles. FrameDone is high for the cycle after edge N+177.
- Back-to-back: a byte accepted any time before the last STOP cycle starts on the edge where STOP ends. The next start bit follows the stop bit with no gap, giving 176 cycles per frame.
- Earliest second accept after a load: the edge following the load edge.

## Test plan
- Reset: assert Rst asynchronously mid-cycle. TX=1, InReady=1, Busy=0 and FrameDone=0 immediately; the outputs hold these values for 200 cycles with InValid=0.
- Single byte, even parity: send 0xA5. TX reads 0,1,0,1,0,0,1,0,1,0,1, each level for exactly 16 cycles. FrameDone pulses once, 177 cycles after the accept edge. Busy then falls.
- Odd parity (PARITY_ODD=1): send 0x00. Data bits are all 0, the parity bit is 1 and the stop bit is 1.
- Back-to-back: send 0x3C and 0xFF with InValid held high. The second accept happens one cycle after the first load. Both frames go out with no idle cycle between stop and start, 352 cycles in total. FrameDone pulses twice, 176 cycles apart.
- Backpressure: hold InValid=1 with 0x55 while the buffer is full. InReady stays 0 until the load, and exactly one transfer of 0x55 occurs.
- Clear mid-DATA: assert Clear during data bit 3 of 0x81 with a second byte buffered. TX=1 on the next edge, the state returns to IDLE, the buffered byte is dropped, there is no FrameDone pulse, and InReady=1.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter (start, 8 data LSB first, parity, stop) at 16 clocks per bit,
// with a one-entry holding buffer so frames can go out back-to-back.
module uart_tx #(
    parameter logic PARITY_ODD = 1'b0
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Clear,
    input  logic [7:0] InData,
    input  logic       InValid,
    output logic       InReady,
    output logic       TX,
    output logic       Busy,
    output logic       FrameDone
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [2:0]  data_cnt_q, data_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  hold_data_q, hold_data_d;
    logic        hold_valid_q, hold_valid_d;
    logic        parity_q, parity_d;
    logic        tx_q, tx_d;
    logic        done_q, done_d;
    logic        bit_end, load, accept;

    assign bit_end   = bit_cnt_q == 4'd15;
    assign accept    = InValid && !hold_valid_q;
    assign load      = hold_valid_q && (state_q == IDLE || (state_q == STOP && bit_end));
    assign InReady   = !hold_valid_q;
    assign TX        = tx_q;
    assign Busy      = state_q != IDLE || hold_valid_q;
    assign FrameDone = done_q;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            data_cnt_q   <= '0;
            shift_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else if (Clear) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            data_cnt_q   <= '0;
            shift_q      <= '0;
            hold_data_q  <= '0;
            hold_valid_q <= 1'b0;
            parity_q     <= 1'b0;
            tx_q         <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            data_cnt_q   <= data_cnt_d;
            shift_q      <= shift_d;
            hold_data_q  <= hold_data_d;
            hold_valid_q <= hold_valid_d;
            parity_q     <= parity_d;
            tx_q         <= tx_d;
            done_q       <= done_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = hold_valid_q ? START : IDLE;
            START:   state_d = bit_end ? DATA : START;
            DATA:    state_d = (bit_end && data_cnt_q == 3'd7) ? PARITY : DATA;
            PARITY:  state_d = bit_end ? STOP : PARITY;
            STOP:    state_d = bit_end ? (hold_valid_q ? START : IDLE) : STOP;
            default: state_d = IDLE;
        endcase
    end

    // Accept and load are mutually exclusive: load needs hold_valid_q, accept needs it clear.
    always_comb begin
        hold_valid_d = accept ? 1'b1 : (load ? 1'b0 : hold_valid_q);
        hold_data_d  = accept ? InData : hold_data_q;
        bit_cnt_d    = (state_q == IDLE) ? 4'd0 : bit_cnt_q + 4'd1;
        data_cnt_d   = (state_q == DATA && bit_end) ? data_cnt_q + 3'd1 : data_cnt_q;
        shift_d      = load ? hold_data_q : ((state_q == DATA && bit_end) ? {1'b0, shift_q[7:1]} : shift_q);
        parity_d     = load ? (^hold_data_q) ^ PARITY_ODD : parity_q;
        done_d       = state_q == STOP && bit_end;
        tx_d         = 1'b1;
        case (state_q)
            IDLE:    tx_d = !load;
            START:   tx_d = bit_end ? shift_q[0] : 1'b0;
            DATA:    tx_d = !bit_end ? tx_q : (data_cnt_q == 3'd7 ? parity_q : shift_q[1]);
            PARITY:  tx_d = bit_end ? 1'b1 : tx_q;
            STOP:    tx_d = !load;
            default: tx_d = 1'b1;
        endcase
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: drives an even-parity and an odd-parity uart_tx with the same stimulus and checks
// both every cycle against a frame-position model, plus hand-computed spot values.
module tb_uart_tx;
    logic       Clk = 1'b0, Rst = 1'b1, Clear = 1'b0, InValid = 1'b0;
    logic [7:0] InData = 8'h00;
    logic [1:0] rdy, tx, busy, done;
    int         cyc = 0, n_cmp = 0, n_bad = 0;

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    uart_tx #(.PARITY_ODD(1'b0)) dut_e (.Clk(Clk), .Rst(Rst), .Clear(Clear), .InData(InData), .InValid(InValid),
        .InReady(rdy[0]), .TX(tx[0]), .Busy(busy[0]), .FrameDone(done[0]));
    uart_tx #(.PARITY_ODD(1'b1)) dut_o (.Clk(Clk), .Rst(Rst), .Clear(Clear), .InData(InData), .InValid(InValid),
        .InReady(rdy[1]), .TX(tx[1]), .Busy(busy[1]), .FrameDone(done[1]));

    // Model: a frame is 176 cycles; m_pos is the cycle index within the frame on the wire.
    logic       m_act [2], m_hold [2], m_done [2];
    logic [7:0] m_frm [2], m_hb [2];
    int         m_pos [2];

    always @(posedge Clk or posedge Rst) begin
        for (int i = 0; i < 2; i++) begin
            if (Rst || Clear) begin
                m_act[i]  <= 1'b0;
                m_pos[i]  <= 0;
                m_hold[i] <= 1'b0;
                m_done[i] <= 1'b0;
            end else begin
                m_done[i] <= m_act[i] && m_pos[i] == 175;
                if (m_act[i] && m_pos[i] != 175) m_pos[i] <= m_pos[i] + 1;
                else if (m_hold[i]) begin
                    m_act[i] <= 1'b1;
                    m_pos[i] <= 0;
                    m_frm[i] <= m_hb[i];
                end else begin
                    m_act[i] <= 1'b0;
                    m_pos[i] <= 0;
                end
                if (InValid && !m_hold[i]) begin
                    m_hold[i] <= 1'b1;
                    m_hb[i]   <= InData;
                end else if (m_hold[i] && (!m_act[i] || m_pos[i] == 175)) m_hold[i] <= 1'b0;
            end
        end
    end

    function automatic logic exp_tx(input int i);
        int k;
        if (!m_act[i]) return 1'b1;
        k = m_pos[i] / 16;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_frm[i][k-1];
        if (k == 9) return logic'(($countones(m_frm[i]) % 2) == 1) ^ logic'(i == 1);
        return 1'b1;
    endfunction

    task automatic check(input string nm, input logic [7:0] got, input logic [7:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, got, want);
        end
    endtask

    always @(negedge Clk) begin
        for (int i = 0; i < 2; i++) begin
            check($sformatf("tx%0d", i), 8'(tx[i]), 8'(exp_tx(i)));
            check($sformatf("ready%0d", i), 8'(rdy[i]), 8'(!m_hold[i]));
            check($sformatf("busy%0d", i), 8'(busy[i]), 8'(m_act[i] || m_hold[i]));
            check($sformatf("done%0d", i), 8'(done[i]), 8'(m_done[i]));
        end
    end

    task automatic at(input int t);
        while (cyc < t) @(negedge Clk);
    endtask

    task automatic send(input logic [7:0] v, output int t);
        InData  = v;
        InValid = 1'b1;
        @(negedge Clk);
        InValid = 1'b0;
        t = cyc;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int a, b;
        logic [10:0] pat;
        pat = 11'b10101001010;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        // asynchronous reset in the middle of a frame
        send(8'hF0, a);
        at(a + 25);
        check("pre_rst_tx", 8'(tx[0]), 8'd0);
        check("pre_rst_busy", 8'(busy[0]), 8'd1);
        @(posedge Clk);
        #3 Rst = 1'b1;
        #1;
        check("rst_tx", 8'(tx[0]), 8'd1);
        check("rst_ready", 8'(rdy[0]), 8'd1);
        check("rst_busy", 8'(busy[0]), 8'd0);
        check("rst_done", 8'(done[0]), 8'd0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;
        b = cyc;
        at(b + 200);
        check("quiet_tx", 8'(tx[0]), 8'd1);
        check("quiet_busy", 8'(busy[1]), 8'd0);
        // 0xA5: even parity 0, odd parity 1
        send(8'hA5, a);
        check("a5_pre_tx", 8'(tx[0]), 8'd1);
        for (int k = 0; k < 11; k++) begin
            at(a + 9 + 16 * k);
            check($sformatf("a5_bit%0d", k), 8'(tx[0]), 8'(pat[k]));
            if (k == 9) check("a5_odd_par", 8'(tx[1]), 8'd1);
        end
        at(a + 176);
        check("a5_done_early", 8'(done[0]), 8'd0);
        at(a + 177);
        check("a5_done", 8'(done[0]), 8'd1);
        check("a5_busy_fall", 8'(busy[0]), 8'd0);
        at(a + 178);
        check("a5_done_once", 8'(done[0]), 8'd0);
        // 0x00: odd-parity bit 1, even-parity bit 0
        send(8'h00, a);
        for (int k = 1; k < 11; k++) begin
            at(a + 9 + 16 * k);
            check($sformatf("z_bit%0d", k), 8'(tx[1]), (k >= 9) ? 8'd1 : 8'd0);
            if (k == 9) check("z_even_par", 8'(tx[0]), 8'd0);
        end
        at(a + 180);
        // back-to-back 0x3C then 0xFF with InValid held high
        InData  = 8'h3C;
        InValid = 1'b1;
        @(negedge Clk);
        a = cyc;
        InData = 8'hFF;
        check("b2b_full", 8'(rdy[0]), 8'd0);
        @(negedge Clk);
        check("b2b_ready_after_load", 8'(rdy[0]), 8'd1);
        @(negedge Clk);
        InValid = 1'b0;
        check("b2b_second_accept", 8'(rdy[0]), 8'd0);
        at(a + 176);
        check("b2b_stop", 8'(tx[0]), 8'd1);
        at(a + 177);
        check("b2b_done1", 8'(done[0]), 8'd1);
        check("b2b_no_gap", 8'(tx[0]), 8'd0);
        at(a + 177 + 9 + 16 * 9);
        check("ff_even_par", 8'(tx[0]), 8'd0);
        check("ff_odd_par", 8'(tx[1]), 8'd1);
        at(a + 353);
        check("b2b_done2", 8'(done[0]), 8'd1);
        at(a + 354);
        check("b2b_idle", 8'(busy[0]), 8'd0);
        // backpressure: 0x55 held while the buffer is full
        send(8'h12, a);
        @(negedge Clk);
        send(8'h34, b);
        InData  = 8'h55;
        InValid = 1'b1;
        at(a + 100);
        check("bp_stall", 8'(rdy[0]), 8'd0);
        at(a + 177);
        check("bp_load", 8'(rdy[0]), 8'd1);
        @(negedge Clk);
        InValid = 1'b0;
        check("bp_taken", 8'(rdy[0]), 8'd0);
        at(a + 529);
        check("bp_done3", 8'(done[0]), 8'd1);
        at(a + 530);
        check("bp_idle", 8'(busy[0]), 8'd0);
        // Clear during data bit 3 of 0x81 with 0x99 buffered
        send(8'h81, a);
        @(negedge Clk);
        send(8'h99, b);
        at(a + 70);
        check("clr_pre_tx", 8'(tx[0]), 8'd0);
        check("clr_pre_full", 8'(rdy[0]), 8'd0);
        Clear = 1'b1;
        @(negedge Clk);
        Clear = 1'b0;
        check("clr_tx", 8'(tx[0]), 8'd1);
        check("clr_ready", 8'(rdy[0]), 8'd1);
        check("clr_busy", 8'(busy[0]), 8'd0);
        check("clr_done", 8'(done[0]), 8'd0);
        at(a + 260);
        check("clr_stays_idle", 8'(busy[0]), 8'd0);
        // Clear wins over a simultaneous accept
        InData  = 8'h77;
        InValid = 1'b1;
        Clear   = 1'b1;
        @(negedge Clk);
        Clear   = 1'b0;
        InValid = 1'b0;
        check("clr_acc_ready", 8'(rdy[0]), 8'd1);
        check("clr_acc_busy", 8'(busy[0]), 8'd0);
        repeat (20) @(negedge Clk);
        check("clr_acc_tx", 8'(tx[0]), 8'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
